fetch_queue: RTL and testbench

Parametrised instruction-fetch front end between the instruction memory bus (IAD/IDT/ACKI_n) and the ID stage. It replaces the single-entry PC register plus IF/ID register pair with a DEPTH-entry prefetch FIFO. It keeps fetching while ID is stalled or interlocked, and discards all prefetched work on a taken branch or jump from EX. ID consumes entries with a valid/ready handshake.

---
 rtl/fetch_queue_if.sv | 48 ++++
 rtl/fetch_queue.sv | 96 +++++++++
 tb/tb_fetch_queue.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundle of the instruction-memory bus and the ID-side
// valid/ready handshake of the fetch queue.
//   master : the fetch queue (drives imem_addr and out_*, count)
//   slave  : memory + ID stage (drive imem_data, imem_ack_n, redirect, out_ready)
// Parameter DEPTH must match the fetch_queue instance so count widths agree.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    logic [31:0]                  imem_addr;
    logic [31:0]                  imem_data;
    logic                         imem_ack_n;
    logic                         redirect;
    logic [31:0]                  redirect_pc;
    logic                         out_valid;
    logic                         out_ready;
    logic [31:0]                  out_pc;
    logic [31:0]                  out_pc4;
    logic [31:0]                  out_ir;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output imem_addr,
        input  imem_data,
        input  imem_ack_n,
        input  redirect,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_pc4,
        output out_ir,
        output count
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output imem_ack_n,
        output redirect,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_pc4,
        input  out_ir,
        input  count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry instruction prefetch FIFO between the instruction
// memory bus and the ID stage. Keeps fetching while ID stalls, flushes on a
// taken branch/jump from EX, and hands entries to ID with valid/ready.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_queue_if.master: imem_addr/imem_data/imem_ack_n,
//          redirect/redirect_pc, out_valid/out_ready/out_pc/out_pc4/out_ir, count
// Optional build macro FETCH_QUEUE_BYPASS_EN: an empty queue forwards the
// fetched word straight to out_* when ID is ready (zero-latency fetch).
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    fetch_queue_if.master  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0]      NOP  = 32'h0000_0013;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [31:0]      pc_mem [DEPTH];
    logic [31:0]      ir_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;

    logic             q_valid;
    logic             pop;
    logic             accept;
    logic             bypass;
    logic             push_q;

    // Handshake decode: accept advances fetch_pc, push_q writes storage.
    always_comb begin
        q_valid = (cnt != '0);
        pop     = q_valid & bus.out_ready;
        accept  = ~bus.imem_ack_n & ((cnt < FULL) | pop) & ~bus.redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass  = ~q_valid & accept & bus.out_ready;
`else
        bypass  = 1'b0;
`endif
        push_q  = accept & ~bypass;
    end

    // Head presentation; an empty queue shows a NOP at pc 0.
    always_comb begin
        bus.out_valid = q_valid;
        bus.out_pc    = q_valid ? pc_mem[rd_ptr] : 32'h0;
        bus.out_ir    = q_valid ? ir_mem[rd_ptr] : NOP;
        bus.out_pc4   = q_valid ? (pc_mem[rd_ptr] + 32'd4) : 32'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass) begin
            bus.out_valid = 1'b1;
            bus.out_pc    = fetch_pc;
            bus.out_ir    = bus.imem_data;
            bus.out_pc4   = fetch_pc + 32'd4;
        end
`endif
    end

    assign bus.imem_addr = fetch_pc;
    assign bus.count     = cnt;

    // Control state; redirect beats any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (push_q) wr_ptr   <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr   <= rd_ptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(push_q) - CNT_W'(pop);
        end
    end

    // Entry storage; contents are meaningless outside [rd_ptr, rd_ptr+cnt).
    always_ff @(posedge clk) begin
        if (push_q) begin
            pc_mem[wr_ptr] <= fetch_pc;
            ir_mem[wr_ptr] <= bus.imem_data;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard per DUT instance.
// dut0 (RESET_PC=0) covers reset, fill/stall, drain, redirect; dut1
// (RESET_PC=FFFF_FFF8) covers wait states and address wrap.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ir;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH)) bus0 ();
    fetch_queue_if #(.DEPTH(DEPTH)) bus1 ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master)
    );

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0003;
    endfunction

    // Instruction memory model: word depends on the address presented.
    always_comb bus0.imem_data = mem_word(bus0.imem_addr);
    always_comb bus1.imem_data = mem_word(bus1.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] pc4);
        exp_t e;
        e.pc  = pc;
        e.pc4 = pc4;
        e.ir  = mem_word(pc);
        return e;
    endfunction

    // Monitors: every accepted handshake (not killed by redirect) pops one entry.
    always @(negedge clk) begin
        if (!rst && bus0.out_valid && bus0.out_ready && !bus0.redirect) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mon0_unexpected: got pc %h, expected no handshake", bus0.out_pc);
            end else begin
                e0 = q0.pop_front();
                check("mon0_pc",  bus0.out_pc,  e0.pc);
                check("mon0_pc4", bus0.out_pc4, e0.pc4);
                check("mon0_ir",  bus0.out_ir,  e0.ir);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus1.out_valid && bus1.out_ready && !bus1.redirect) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mon1_unexpected: got pc %h, expected no handshake", bus1.out_pc);
            end else begin
                e1 = q1.pop_front();
                check("mon1_pc",  bus1.out_pc,  e1.pc);
                check("mon1_pc4", bus1.out_pc4, e1.pc4);
                check("mon1_ir",  bus1.out_ir,  e1.ir);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus0.imem_ack_n = 1'b1; bus0.out_ready = 1'b0;
        bus0.redirect = 1'b0;   bus0.redirect_pc = 32'h0;
        bus1.imem_ack_n = 1'b1; bus1.out_ready = 1'b0;
        bus1.redirect = 1'b0;   bus1.redirect_pc = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_count",  32'(bus0.count), 32'd0);
        check("rst_valid",  32'(bus0.out_valid), 32'd0);
        check("rst_ir",     bus0.out_ir, 32'h0000_0013);
        check("rst_pc",     bus0.out_pc, 32'h0);
        check("rst_pc4",    bus0.out_pc4, 32'h0);
        check("rst_addr",   bus0.imem_addr, 32'h0);
        check("rst_addr1",  bus1.imem_addr, 32'hFFFF_FFF8);

        // Fill and stall: ID not ready for 10 cycles
        cyc();
        bus0.imem_ack_n = 1'b0;
        bus0.out_ready  = 1'b0;
        repeat (10) cyc();
        @(negedge clk);
        check("full_count", 32'(bus0.count), 32'd4);
        check("full_addr",  bus0.imem_addr, 32'h10);
        check("full_pc",    bus0.out_pc, 32'h0);
        check("full_valid", 32'(bus0.out_valid), 32'd1);
        check("full_ir",    bus0.out_ir, mem_word(32'h0));

        // Drain while streaming: 6 more fetches, then memory idles
        cyc();
        check("stall_addr", bus0.imem_addr, 32'h10);
        for (int i = 0; i < 10; i++) q0.push_back(mk(32'(i * 4), 32'(i * 4 + 4)));
        bus0.out_ready = 1'b1;
        repeat (6) cyc();
        bus0.imem_ack_n = 1'b1;
        repeat (5) cyc();
        @(negedge clk);
        check("drain_count", 32'(bus0.count), 32'd0);
        check("drain_addr",  bus0.imem_addr, 32'h28);
        check("drain_valid", 32'(bus0.out_valid), 32'd0);
        check("drain_pc4",   bus0.out_pc4, 32'h0);
        check("drain_q",     32'(q0.size()), 32'd0);

        // Fill, then redirect with push and pop in the same cycle
        cyc();
        bus0.imem_ack_n = 1'b0;
        bus0.out_ready  = 1'b0;
        repeat (5) cyc();
        bus0.out_ready   = 1'b1;
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 32'h0000_0102;
        cyc();
        bus0.redirect  = 1'b0;
        bus0.out_ready = 1'b0;
        @(negedge clk);
        check("redir_count", 32'(bus0.count), 32'd0);
        check("redir_valid", 32'(bus0.out_valid), 32'd0);
        check("redir_addr",  bus0.imem_addr, 32'h100);
        cyc();
        bus0.imem_ack_n = 1'b1;
        @(negedge clk);
        check("tgt_pc",    bus0.out_pc, 32'h100);
        check("tgt_valid", 32'(bus0.out_valid), 32'd1);
        check("tgt_count", 32'(bus0.count), 32'd1);
        check("tgt_addr",  bus0.imem_addr, 32'h104);
        q0.push_back(mk(32'h100, 32'h104));
        cyc();
        bus0.out_ready = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        check("tgt_drain", 32'(bus0.count), 32'd0);

        // Wait states and address wrap on dut1
        q1.push_back(mk(32'hFFFF_FFF8, 32'hFFFF_FFFC));
        q1.push_back(mk(32'hFFFF_FFFC, 32'h0000_0000));
        q1.push_back(mk(32'h0000_0000, 32'h0000_0004));
        cyc();
        bus1.out_ready  = 1'b1;
        bus1.imem_ack_n = 1'b0;
        @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
        check("byp_valid", 32'(bus1.out_valid), 32'd1);
        check("byp_ir",    bus1.out_ir, mem_word(32'hFFFF_FFF8));
        check("byp_count", 32'(bus1.count), 32'd0);
`else
        check("nobyp_valid", 32'(bus1.out_valid), 32'd0);
        check("nobyp_count", 32'(bus1.count), 32'd0);
`endif
        cyc();
        bus1.imem_ack_n = 1'b1;
        @(negedge clk);
        check("wait_addr_a", bus1.imem_addr, 32'hFFFF_FFFC);
        cyc();
        bus1.imem_ack_n = 1'b0;
        @(negedge clk);
        check("wait_addr_b", bus1.imem_addr, 32'hFFFF_FFFC);
        cyc();
        bus1.imem_ack_n = 1'b1;
        @(negedge clk);
        check("wrap_addr", bus1.imem_addr, 32'h0);
        cyc();
        bus1.imem_ack_n = 1'b0;
        cyc();
        bus1.imem_ack_n = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        check("wrap_end_addr",  bus1.imem_addr, 32'h4);
        check("wrap_end_count", 32'(bus1.count), 32'd0);
        check("wrap_q",         32'(q1.size()), 32'd0);
        check("final_q0",       32'(q0.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
